// File: rtl/lru_state_updater_pkg.sv
// Shared LRU code points and flush FSM state encoding for the 2-way cache LRU
// writer (lru_state_updater) and reader (lower_lru_way_finder).
package lru_state_updater_pkg;

  localparam logic [1:0] LRU_EMPTY   = 2'b00;  // victim is way0
  localparam logic [1:0] LRU_W0_MRU  = 2'b01;  // victim is way1
  localparam logic [1:0] LRU_W1_MRU  = 2'b10;  // victim is way0
  localparam logic [1:0] LRU_ILLEGAL = 2'b11;  // never stored

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSweep = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Code recorded after an access to the given way.
  function automatic logic [1:0] lru_fill_code(input logic way);
    return way ? LRU_W1_MRU : LRU_W0_MRU;
  endfunction

endpackage

// File: rtl/lru_state_updater_if.sv
// Controller-side bundle for the LRU state updater: read port, access update,
// single-set invalidate and flush handshake.
interface lru_state_updater_if #(
  parameter int unsigned INDEX_WIDTH = 2
) ();

  logic [INDEX_WIDTH-1:0] rd_index;
  logic [1:0]             rd_lru;
  logic                   upd_valid;
  logic [INDEX_WIDTH-1:0] upd_index;
  logic                   upd_way;
  logic                   upd_ready;
  logic                   inv_valid;
  logic [INDEX_WIDTH-1:0] inv_index;
  logic                   flush_req;
  logic                   flush_busy;
  logic                   flush_done;

  modport master (
    output rd_index, upd_valid, upd_index, upd_way, inv_valid, inv_index, flush_req,
    input  rd_lru, upd_ready, flush_busy, flush_done
  );

  modport slave (
    input  rd_index, upd_valid, upd_index, upd_way, inv_valid, inv_index, flush_req,
    output rd_lru, upd_ready, flush_busy, flush_done
  );

endinterface

// File: rtl/lru_next_state.sv
// Per-set LRU encoder: maps an access (way) or invalidate onto the next 2-bit
// code; the counterpart of the victim decode in the way finder.
module lru_next_state
  import lru_state_updater_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       upd,
  input  logic       way,
  input  logic       inv,
  output logic [1:0] nxt
);

  // Update beats invalidate so a fill issued alongside its own invalidate sticks.
  always_comb begin
    nxt = cur;
    if (upd) begin
      nxt = lru_fill_code(way);
    end else if (inv) begin
      nxt = LRU_EMPTY;
    end
  end

endmodule

// File: rtl/lru_state_updater.sv
// LRU code storage for every set of a 2-way cache, with access update,
// single-set invalidate and a whole-cache flush sweep.
module lru_state_updater
  import lru_state_updater_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 2,
  parameter int unsigned NUM_SETS    = 4
) (
  input  logic                clk,
  input  logic                reset,
  lru_state_updater_if.slave  bus
);

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]             lru_q   [NUM_SETS];
  logic [1:0]             set_nxt [NUM_SETS];

  logic upd_ready, flush_busy, flush_done;
  logic upd_fire, inv_fire, sweeping;

  assign sweeping = (state_q == StSweep);
  assign upd_fire = bus.upd_valid && upd_ready;
  // Invalidates share the update window so nothing lands between sweep and DONE.
  assign inv_fire = bus.inv_valid && (state_q == StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.flush_req) begin
          state_d = StSweep;
          cnt_d   = '0;
        end
      end
      StSweep: begin
        cnt_d = cnt_q + INDEX_WIDTH'(1);
        if (cnt_q == INDEX_WIDTH'(NUM_SETS - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    upd_ready  = 1'b0;
    flush_busy = 1'b0;
    flush_done = 1'b0;
    unique case (state_q)
      StIdle:  upd_ready  = 1'b1;
      StSweep: flush_busy = 1'b1;
      StDone:  flush_done = 1'b1;
      default: upd_ready  = 1'b0;
    endcase
  end

  assign bus.upd_ready  = upd_ready;
  assign bus.flush_busy = flush_busy;
  assign bus.flush_done = flush_done;

  for (genvar i = 0; i < NUM_SETS; i++) begin : g_set
    lru_next_state u_next (
      .cur (lru_q[i]),
      .upd (upd_fire && (bus.upd_index == INDEX_WIDTH'(i))),
      .way (bus.upd_way),
      .inv (inv_fire && (bus.inv_index == INDEX_WIDTH'(i))),
      .nxt (set_nxt[i])
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lru_q[i] <= LRU_EMPTY;
      end else if (sweeping && (cnt_q == INDEX_WIDTH'(i))) begin
        lru_q[i] <= LRU_EMPTY;
      end else begin
        lru_q[i] <= set_nxt[i];
      end
    end
  end

  assign bus.rd_lru = lru_q[bus.rd_index];

endmodule

// File: tb/tb_lru_state_updater.sv
// Directed bench for lru_state_updater: reset, update/invalidate, collisions,
// flush sweep timing, held update across a sweep and reset mid-sweep.
module tb_lru_state_updater;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  lru_state_updater_if #(.INDEX_WIDTH(2)) bus ();

  lru_state_updater #(
    .INDEX_WIDTH (2),
    .NUM_SETS    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // The illegal code must never be observable on the read port.
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp = n_cmp + 1;
      if (bus.rd_lru === 2'b11) begin
        n_bad = n_bad + 1;
        $display("FAIL illegal_code: set %0d reads %b, required not 11", bus.rd_index, bus.rd_lru);
      end
    end
  end

  function automatic logic victim(input logic [1:0] code);
    return (code == 2'b01);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int idx, output logic [1:0] v);
    bus.rd_index = idx[1:0];
    #1;
    v = bus.rd_lru;
  endtask

  task automatic upd(input int idx, input logic way);
    bus.upd_valid = 1'b1;
    bus.upd_index = idx[1:0];
    bus.upd_way   = way;
  endtask

  task automatic idle_inputs();
    bus.upd_valid = 1'b0;
    bus.inv_valid = 1'b0;
    bus.flush_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] v;
    for (int s = 0; s < 4; s++) begin
      rd(s, v);
      n_cmp++;
      if (v !== 2'b00) begin
        n_bad++;
        $display("FAIL reset_set%0d: got %b, required 00", s, v);
      end
    end
    n_cmp++;
    if (bus.upd_ready !== 1'b1 || bus.flush_busy !== 1'b0 || bus.flush_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: ready/busy/done=%b%b%b, required 100",
               bus.upd_ready, bus.flush_busy, bus.flush_done);
    end
  endtask

  task automatic test_update();
    logic [1:0] v;
    upd(2, 1'b0);
    rd(2, v);
    n_cmp++;
    if (v !== 2'b00) begin
      n_bad++;
      $display("FAIL no_bypass: set2 got %b before edge, required 00", v);
    end
    step();
    upd(2, 1'b1);
    rd(2, v);
    n_cmp++;
    if (v !== 2'b01 || victim(v) !== 1'b1) begin
      n_bad++;
      $display("FAIL upd_way0: set2 got %b victim %b, required 01 victim 1", v, victim(v));
    end
    step();
    upd(2, 1'b1);
    rd(2, v);
    n_cmp++;
    if (v !== 2'b10 || victim(v) !== 1'b0) begin
      n_bad++;
      $display("FAIL upd_way1: set2 got %b victim %b, required 10 victim 0", v, victim(v));
    end
    step();
    idle_inputs();
    rd(2, v);
    n_cmp++;
    if (v !== 2'b10) begin
      n_bad++;
      $display("FAIL upd_repeat: set2 got %b, required 10", v);
    end
  endtask

  task automatic test_upd_inv_collision();
    logic [1:0] v;
    upd(1, 1'b1);
    bus.inv_valid = 1'b1;
    bus.inv_index = 2'd1;
    step();
    idle_inputs();
    rd(1, v);
    n_cmp++;
    if (v !== 2'b10) begin
      n_bad++;
      $display("FAIL same_idx_collision: set1 got %b, required 10", v);
    end
    bus.inv_valid = 1'b1;
    bus.inv_index = 2'd1;
    step();
    idle_inputs();
    rd(1, v);
    n_cmp++;
    if (v !== 2'b00) begin
      n_bad++;
      $display("FAIL invalidate: set1 got %b, required 00", v);
    end
    // Different indices: both apply (set2 holds 10 from the update test).
    upd(0, 1'b0);
    bus.inv_valid = 1'b1;
    bus.inv_index = 2'd2;
    step();
    idle_inputs();
    rd(0, v);
    n_cmp++;
    if (v !== 2'b01) begin
      n_bad++;
      $display("FAIL diff_idx_upd: set0 got %b, required 01", v);
    end
    rd(2, v);
    n_cmp++;
    if (v !== 2'b00) begin
      n_bad++;
      $display("FAIL diff_idx_inv: set2 got %b, required 00", v);
    end
  endtask

  task automatic fill_way0();
    for (int s = 0; s < 4; s++) begin
      upd(s, 1'b0);
      step();
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    logic [1:0] v;
    logic [1:0] exp;
    fill_way0();
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (bus.flush_busy !== 1'b1 || bus.upd_ready !== 1'b0 || bus.flush_done !== 1'b0) begin
        n_bad++;
        $display("FAIL sweep_flags_c%0d: busy/ready/done=%b%b%b, required 100", k,
                 bus.flush_busy, bus.upd_ready, bus.flush_done);
      end
      for (int s = 0; s < 4; s++) begin
        exp = (s < k) ? 2'b00 : 2'b01;
        rd(s, v);
        n_cmp++;
        if (v !== exp) begin
          n_bad++;
          $display("FAIL sweep_order_c%0d_set%0d: got %b, required %b", k, s, v, exp);
        end
      end
      step();
    end
    n_cmp++;
    if (bus.flush_done !== 1'b1 || bus.flush_busy !== 1'b0 || bus.upd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL done_flags: done/busy/ready=%b%b%b, required 100",
               bus.flush_done, bus.flush_busy, bus.upd_ready);
    end
    rd(3, v);
    n_cmp++;
    if (v !== 2'b00) begin
      n_bad++;
      $display("FAIL last_set_cleared: set3 got %b, required 00", v);
    end
    step();
    n_cmp++;
    if (bus.flush_done !== 1'b0 || bus.upd_ready !== 1'b1 || bus.flush_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL back_to_idle: done/ready/busy=%b%b%b, required 010",
               bus.flush_done, bus.upd_ready, bus.flush_busy);
    end
  endtask

  task automatic test_held_update();
    logic [1:0] v;
    upd(3, 1'b0);
    step();
    idle_inputs();
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    upd(3, 1'b1);
    bus.inv_valid = 1'b1;
    bus.inv_index = 2'd3;
    for (int k = 0; k < 4; k++) begin
      rd(3, v);
      n_cmp++;
      if (v !== 2'b01 || bus.upd_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL held_in_sweep_c%0d: set3 %b ready %b, required 01 ready 0",
                 k, v, bus.upd_ready);
      end
      step();
    end
    bus.inv_valid = 1'b0;
    rd(3, v);
    n_cmp++;
    if (v !== 2'b00 || bus.upd_ready !== 1'b0 || bus.flush_done !== 1'b1) begin
      n_bad++;
      $display("FAIL held_in_done: set3 %b ready %b done %b, required 00 0 1",
               v, bus.upd_ready, bus.flush_done);
    end
    step();
    rd(3, v);
    n_cmp++;
    if (v !== 2'b00 || bus.upd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL held_first_idle: set3 %b ready %b, required 00 ready 1", v, bus.upd_ready);
    end
    step();
    idle_inputs();
    rd(3, v);
    n_cmp++;
    if (v !== 2'b10) begin
      n_bad++;
      $display("FAIL held_accepted: set3 got %b, required 10", v);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [1:0] v;
    fill_way0();
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    step();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.flush_busy !== 1'b0 || bus.flush_done !== 1'b0 || bus.upd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_flags: busy/done/ready=%b%b%b, required 001",
               bus.flush_busy, bus.flush_done, bus.upd_ready);
    end
    for (int s = 0; s < 4; s++) begin
      rd(s, v);
      n_cmp++;
      if (v !== 2'b00) begin
        n_bad++;
        $display("FAIL abort_set%0d: got %b, required 00", s, v);
      end
    end
    step();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      n_cmp++;
      if (bus.flush_done !== 1'b0 || bus.flush_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_no_done_c%0d: done %b busy %b, required 0 0",
                 c, bus.flush_done, bus.flush_busy);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.rd_index  = '0;
    bus.upd_index = '0;
    bus.upd_way   = 1'b0;
    bus.inv_index = '0;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    test_reset();
    step();
    test_update();
    test_upd_inv_collision();
    test_flush();
    test_held_update();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
